// File: rtl/kernel_cc_fifo_rr_arb_if.sv
// Producer/downstream bundle for the shared ap_fifo write-port arbiter.
// Latency: none, this is wiring only.
// Backpressure: req_full_n and out_full_n carry the ap_fifo not-full handshake.
interface kernel_cc_fifo_rr_arb_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
   logic [NUM_REQ-1:0]            req_full_n;
   logic                          out_write;
   logic [DATA_WIDTH-1:0]         out_din;
   logic                          out_full_n;
   logic                          grant_valid;
   logic [ID_W-1:0]               grant_id;

   // Producers plus downstream FIFO side.
   modport master (
      output req_write, req_din, out_full_n,
      input  req_full_n, out_write, out_din, grant_valid, grant_id
   );

   // Arbiter side.
   modport slave (
      input  req_write, req_din, out_full_n,
      output req_full_n, out_write, out_din, grant_valid, grant_id
   );
endinterface

// File: rtl/kernel_cc_fifo_rr_arb.sv
// Round-robin arbiter sharing one ap_fifo write port among NUM_REQ producers, bursts up to MAX_BURST.
// Latency: grant one cycle after request, accepted word appears on out_write one cycle later.
// Backpressure: single output register, producers see full_n only when the stage can accept.
module kernel_cc_fifo_rr_arb #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BURST  = 4
) (
   input logic                     clk,
   input logic                     reset,
   kernel_cc_fifo_rr_arb_if.slave  bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                 state_q, state_d;
   logic [ID_W-1:0]        gid_q, gid_d;
   logic [ID_W-1:0]        last_q, last_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   out_vld_q;
   logic [DATA_WIDTH-1:0]  out_dat_q;

   logic                   ready;
   logic                   cur_req;
   logic                   xfer;
   logic                   release_g;
   logic [NUM_REQ-1:0]     full_n_vec;
   logic [DATA_WIDTH-1:0]  sel_dat;
   logic                   pick_found;
   logic [ID_W-1:0]        pick_id;
   logic [ID_W-1:0]        pick_base;
   logic [ID_W-1:0]        cand;

   // The output stage can take a word when empty or when it drains this cycle.
   assign ready     = !out_vld_q | bus.out_full_n;
   assign cur_req   = bus.req_write[gid_q];
   assign xfer      = (state_q == GRANT) & cur_req & ready;
   assign release_g = (state_q == GRANT) &
                      ((xfer & (cnt_q == CNT_W'(MAX_BURST - 1))) | !cur_req);

   // Only the granted producer sees ready; no path from req_write.
   always_comb begin
      full_n_vec = '0;
      if (state_q == GRANT && ready) full_n_vec[gid_q] = 1'b1;
   end

   // Mux the granted producer's word into the output register.
   always_comb begin
      sel_dat = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gid_q == ID_W'(i)) sel_dat = bus.req_din[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Round-robin pick; a releasing owner scans from itself+1 so it has lowest priority.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      cand       = '0;
      pick_base  = (state_q == GRANT) ? gid_q : last_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(pick_base) + k) % NUM_REQ);
         if (!pick_found && bus.req_write[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   // Grant FSM next-state: hand off without a bubble when another requester is waiting.
   always_comb begin
      state_d = state_q;
      gid_d   = gid_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (|bus.req_write) begin
               state_d = GRANT;
               gid_d   = pick_id;
               cnt_d   = '0;
            end
         end
         default: begin
            if (release_g) begin
               last_d = gid_q;
               cnt_d  = '0;
               if (pick_found) gid_d = pick_id;
               else            state_d = IDLE;
            end else if (xfer) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   // Grant FSM registers; last starts at NUM_REQ-1 so producer 0 wins first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gid_q   <= '0;
         last_q  <= ID_W'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gid_q   <= gid_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output register: load on transfer, empty once downstream takes the word.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_vld_q <= 1'b0;
         out_dat_q <= '0;
      end else if (xfer) begin
         out_vld_q <= 1'b1;
         out_dat_q <= sel_dat;
      end else if (bus.out_full_n) begin
         out_vld_q <= 1'b0;
      end
   end

   assign bus.req_full_n  = full_n_vec;
   assign bus.out_write   = out_vld_q;
   assign bus.out_din     = out_dat_q;
   assign bus.grant_valid = (state_q == GRANT);
   assign bus.grant_id    = gid_q;

endmodule

// File: tb/tb_kernel_cc_fifo_rr_arb.sv
module tb_kernel_cc_fifo_rr_arb;
   localparam int N  = 4;
   localparam int DW = 64;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   kernel_cc_fifo_rr_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

   kernel_cc_fifo_rr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] exp_q[$];
   bit            rand_mode = 1'b0;
   logic [DW-1:0] base[N];
   int            sent[N];
   int            lim[N];
   bit            want[N];
   longint        rexp[N];
   int            popped_p[N];
   int            popped = 0;
   logic [N-1:0]  fire;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a downstream write happens at the next posedge when out_write & out_full_n.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (bus.out_write === 1'b1 && bus.out_full_n === 1'b1) begin
            popped++;
            if (rand_mode) begin
               int id;
               id = int'(bus.out_din[63:32]);
               if (id >= N) begin
                  chk("rand_prod_id", 64'(id), 64'(0));
               end else begin
                  chk("rand_order", 64'(bus.out_din[31:0]), 64'(rexp[id][31:0]));
                  rexp[id]++;
                  popped_p[id]++;
               end
            end else if (exp_q.size() == 0) begin
               chk("extra_word", bus.out_din, 64'hdead_0000_0000_beef ^ bus.out_din ^ 64'h1);
            end else begin
               chk("out_din", bus.out_din, exp_q.pop_front());
            end
         end
      end
   end

   // One cycle: drive producer inputs at negedge, note handshakes, advance after posedge.
   task automatic step();
      for (int i = 0; i < N; i++) begin
         bus.req_write[i] = want[i] && (sent[i] < lim[i]);
         bus.req_din[i*DW +: DW] = base[i] + DW'(sent[i]);
      end
      #1;
      fire = bus.req_write & bus.req_full_n;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N; i++) if (fire[i]) sent[i]++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.out_full_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         want[i] = 1'b0;
         sent[i] = 0;
         lim[i]  = 0;
      end
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
      chk(name, 64'(exp_q.size()), 64'(0));
      for (int i = 0; i < N; i++) want[i] = 1'b0;
      step();
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      int tot;
      bus.req_write  = '0;
      bus.req_din    = '0;
      bus.out_full_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         base[i] = '0; sent[i] = 0; lim[i] = 0; want[i] = 1'b0;
         rexp[i] = 0; popped_p[i] = 0;
      end
      @(negedge clk);

      // Reset state
      do_reset();
      chk("rst_grant_valid", 64'(bus.grant_valid), 64'(0));
      chk("rst_grant_id", 64'(bus.grant_id), 64'(0));
      chk("rst_out_write", 64'(bus.out_write), 64'(0));
      chk("rst_out_din", bus.out_din, 64'(0));
      chk("rst_req_full_n", 64'(bus.req_full_n), 64'(0));

      // Single producer, six words, re-granted after four with no gap
      base[1] = 64'h10; lim[1] = 6; want[1] = 1'b1;
      for (int k = 0; k < 6; k++) exp_q.push_back(64'h10 + 64'(k));
      step();
      chk("t1_grant_valid", 64'(bus.grant_valid), 64'(1));
      chk("t1_grant_id", 64'(bus.grant_id), 64'(1));
      chk("t1_req_full_n", 64'(bus.req_full_n), 64'b0010);
      chk("t1_no_write_yet", 64'(bus.out_write), 64'(0));
      for (int k = 2; k <= 7; k++) begin
         step();
         chk("t1_stream_write", 64'(bus.out_write), 64'(1));
         if (k == 2) chk("t1_first_word", bus.out_din, 64'h10);
         if (k == 5) chk("t1_regrant_id", 64'({bus.grant_valid, bus.grant_id}), 64'({1'b1, 2'd1}));
      end
      step();
      chk("t1_write_done", 64'(bus.out_write), 64'(0));
      chk("t1_grant_drop", 64'(bus.grant_valid), 64'(0));
      drain("t1_drain");

      // Contention between producers 0 and 2
      do_reset();
      base[0] = 64'h100; lim[0] = 8; want[0] = 1'b1;
      base[2] = 64'h200; lim[2] = 8; want[2] = 1'b1;
      for (int k = 0; k < 4; k++) exp_q.push_back(64'h100 + 64'(k));
      for (int k = 0; k < 4; k++) exp_q.push_back(64'h200 + 64'(k));
      for (int k = 4; k < 8; k++) exp_q.push_back(64'h100 + 64'(k));
      for (int k = 4; k < 8; k++) exp_q.push_back(64'h200 + 64'(k));
      for (int k = 1; k <= 17; k++) begin
         step();
         if (k <= 16 && ((k - 1) % 4) == 0)
            chk("t2_grant_id", 64'(bus.grant_id), ((((k - 1) / 4) % 2) == 1) ? 64'(2) : 64'(0));
         if (k >= 2) chk("t2_no_bubble", 64'(bus.out_write), 64'(1));
      end
      drain("t2_drain");

      // Backpressure for three cycles mid-burst
      do_reset();
      base[0] = 64'h300; lim[0] = 6; want[0] = 1'b1;
      base[1] = 64'h310; lim[1] = 4; want[1] = 1'b1;
      for (int k = 0; k < 4; k++) exp_q.push_back(64'h300 + 64'(k));
      for (int k = 0; k < 4; k++) exp_q.push_back(64'h310 + 64'(k));
      exp_q.push_back(64'h304);
      exp_q.push_back(64'h305);
      step();
      step();
      step();
      for (int k = 0; k < 3; k++) begin
         bus.out_full_n = 1'b0;
         #1;
         chk("t3_full_n_low", 64'(bus.req_full_n), 64'(0));
         chk("t3_hold_write", 64'(bus.out_write), 64'(1));
         chk("t3_hold_din", bus.out_din, 64'h301);
         step();
      end
      bus.out_full_n = 1'b1;
      drain("t3_drain");

      // Early release by producer 3 while producer 1 waits
      do_reset();
      base[3] = 64'h330; lim[3] = 2; want[3] = 1'b1;
      base[1] = 64'h310; lim[1] = 4;
      exp_q.push_back(64'h330);
      exp_q.push_back(64'h331);
      for (int k = 0; k < 4; k++) exp_q.push_back(64'h310 + 64'(k));
      step();
      chk("t4_grant3", 64'(bus.grant_id), 64'(3));
      want[1] = 1'b1;
      step();
      step();
      chk("t4_still3", 64'({bus.grant_valid, bus.grant_id}), 64'({1'b1, 2'd3}));
      step();
      chk("t4_pass_to_1", 64'(bus.grant_id), 64'(1));
      chk("t4_full_n_1", 64'(bus.req_full_n), 64'b0010);
      drain("t4_drain");

      // Reset while a word is held in the output stage
      do_reset();
      base[0] = 64'h500; lim[0] = 8; want[0] = 1'b1;
      exp_q.push_back(64'h500);
      step();
      step();
      step();
      reset = 1'b1;
      bus.out_full_n = 1'b0;
      step();
      reset = 1'b0;
      bus.out_full_n = 1'b1;
      chk("t5_out_write", 64'(bus.out_write), 64'(0));
      chk("t5_grant_valid", 64'(bus.grant_valid), 64'(0));
      chk("t5_req_full_n", 64'(bus.req_full_n), 64'(0));
      lim[0] = sent[0] + 4;
      base[1] = 64'h510; lim[1] = 4; want[1] = 1'b1;
      for (int k = 2; k < 6; k++) exp_q.push_back(64'h500 + 64'(k));
      for (int k = 0; k < 4; k++) exp_q.push_back(64'h510 + 64'(k));
      step();
      chk("t5_first_grant", 64'({bus.grant_valid, bus.grant_id}), 64'({1'b1, 2'd0}));
      drain("t5_drain");

      // Random traffic and backpressure, per-producer order and conservation
      do_reset();
      rand_mode = 1'b1;
      popped = 0;
      for (int i = 0; i < N; i++) begin
         base[i] = 64'(i) << 32;
         lim[i] = 1_000_000;
         rexp[i] = 0;
         popped_p[i] = 0;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) want[i] = ($urandom_range(0, 3) != 0);
         bus.out_full_n = ($urandom_range(0, 3) != 0);
         step();
      end
      for (int i = 0; i < N; i++) want[i] = 1'b0;
      bus.out_full_n = 1'b1;
      for (int c = 0; c < 10; c++) step();
      tot = 0;
      for (int i = 0; i < N; i++) begin
         tot += sent[i];
         chk("rand_per_prod_count", 64'(popped_p[i]), 64'(sent[i]));
      end
      chk("rand_total_words", 64'(popped), 64'(tot));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
